// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD frame scheduler.
// Framebuffer geometry, start pulse width and scheduler states.
package lcd_pkg;

    localparam int FB_ADDR_W       = 10;
    localparam int FB_DATA_W       = 8;
    localparam int FB_DEPTH        = 1024;
    localparam int START_PULSE_CYC = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        REFRESH = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fb_bank.sv
// One 1024x8 framebuffer bank: synchronous write, registered read.
// Ports: clk, rst (clears read register only), we_i/waddr_i/wdata_i, raddr_i -> rdata_o.
module fb_bank
    import lcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] waddr_i,
    input  logic [FB_DATA_W-1:0] wdata_i,
    input  logic [FB_ADDR_W-1:0] raddr_i,
    output logic [FB_DATA_W-1:0] rdata_o
);

    logic [FB_DATA_W-1:0] mem [FB_DEPTH];
    logic [FB_DATA_W-1:0] rdata_q;
    logic [FB_DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = mem[raddr_i];
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_frame_sched.sv
// Frame scheduler and double-buffer owner: periodic Driver starts, bank swap at frame ticks.
// Ports: clk/rst, enable_i, render_* (back-bank writes, swap request), render_ready_o,
//        drv_start_o/drv_addr_i/drv_data_o (front-bank Driver port), front_sel_o, frame_skip_o.
// Optional: LCD_FB_CLEAR_ON_SWAP_EN zero-fills the back bank after reset and after each swap.
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int FRAME_DIV   = 1666667,
    parameter int REFRESH_CYC = 1200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 render_we_i,
    input  logic [FB_ADDR_W-1:0] render_addr_i,
    input  logic [FB_DATA_W-1:0] render_data_i,
    input  logic                 render_done_i,
    output logic                 render_ready_o,
    output logic                 drv_start_o,
    input  logic [FB_ADDR_W-1:0] drv_addr_i,
    output logic [FB_DATA_W-1:0] drv_data_o,
    output logic                 front_sel_o,
    output logic [7:0]           frame_skip_o
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_DIV - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_PULSE_CYC - 1);

    sched_state_t   state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic           front_sel_q, front_sel_d;
    logic           swap_pend_q, swap_pend_d;
    logic [7:0]     skip_q, skip_d;
    logic           rd_sel_q, rd_sel_d;
    logic           tick;
    logic           swap_apply;

    logic                 wr_en;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [FB_DATA_W-1:0] wr_data;
    logic [FB_DATA_W-1:0] rd0, rd1;

    assign tick       = (frame_cnt_q == FRAME_LAST);
    assign swap_apply = (state_q == IDLE) && tick && swap_pend_q;

    always_comb begin
        frame_cnt_d = tick ? '0 : frame_cnt_q + CNT_W'(1);
        state_d     = state_q;
        phase_d     = phase_q + CNT_W'(1);
        front_sel_d = front_sel_q;
        swap_pend_d = swap_pend_q;
        skip_d      = skip_q;
        // Read mux select follows the bank that was addressed last cycle
        rd_sel_d    = front_sel_q;

        if (render_done_i && render_ready_o) begin
            swap_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (tick) begin
                    if (swap_pend_q) begin
                        front_sel_d = ~front_sel_q;
                        swap_pend_d = 1'b0;
                    end
                    if (enable_i) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (phase_q == START_LAST) begin
                    state_d = REFRESH;
                    phase_d = '0;
                end
            end
            REFRESH: begin
                if (phase_q == REFRESH_LAST) begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // Front bank is locked while the Driver may still be reading it
        if (tick && (state_q != IDLE) && (skip_q != 8'hFF)) begin
            skip_d = skip_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_q     <= '0;
            front_sel_q <= 1'b0;
            swap_pend_q <= 1'b0;
            skip_q      <= '0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            front_sel_q <= front_sel_d;
            swap_pend_q <= swap_pend_d;
            skip_q      <= skip_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

`ifdef LCD_FB_CLEAR_ON_SWAP_EN
    logic                 clr_busy_q, clr_busy_d;
    logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (clr_busy_q) begin
            clr_addr_d = clr_addr_q + FB_ADDR_W'(1);
            if (clr_addr_q == '1) begin
                clr_busy_d = 1'b0;
            end
        end
        if (swap_apply) begin
            clr_busy_d = 1'b1;
            clr_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_busy_q <= 1'b1;
            clr_addr_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign render_ready_o = ~swap_pend_q & ~clr_busy_q;
`else
    assign render_ready_o = ~swap_pend_q;
`endif

    always_comb begin
        wr_en   = render_we_i & render_ready_o;
        wr_addr = render_addr_i;
        wr_data = render_data_i;
`ifdef LCD_FB_CLEAR_ON_SWAP_EN
        // Renderer is held off while clearing, so the port is free
        if (clr_busy_q) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
            wr_data = '0;
        end
`endif
    end

    // Writes always target the back bank (~front_sel_q)
    fb_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en & front_sel_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (drv_addr_i),
        .rdata_o (rd0)
    );

    fb_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en & ~front_sel_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (drv_addr_i),
        .rdata_o (rd1)
    );

    assign drv_data_o   = rd_sel_q ? rd1 : rd0;
    assign drv_start_o  = (state_q == START);
    assign front_sel_o  = front_sel_q;
    assign frame_skip_o = skip_q;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed bench for lcd_frame_sched: start timing, swaps, dropped writes,
// disabled refresh, frame-skip saturation and (optionally) the clear engine.
module tb_lcd_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic       enable_i = 1'b0;
    logic       render_we_i = 1'b0;
    logic [9:0] render_addr_i = '0;
    logic [7:0] render_data_i = '0;
    logic       render_done_i = 1'b0;
    logic [9:0] drv_addr_i = '0;

    logic       render_ready_o, drv_start_o, front_sel_o;
    logic [7:0] drv_data_o, frame_skip_o;
    logic       render_ready_2, drv_start_2, front_sel_2;
    logic [7:0] drv_data_2, frame_skip_2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cyc2 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
        if (rst2) cyc2 <= 0;
        else cyc2 <= cyc2 + 1;
    end

    lcd_frame_sched #(.FRAME_DIV(100), .REFRESH_CYC(40)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i),
        .render_we_i(render_we_i), .render_addr_i(render_addr_i),
        .render_data_i(render_data_i), .render_done_i(render_done_i),
        .render_ready_o(render_ready_o), .drv_start_o(drv_start_o),
        .drv_addr_i(drv_addr_i), .drv_data_o(drv_data_o),
        .front_sel_o(front_sel_o), .frame_skip_o(frame_skip_o)
    );

    lcd_frame_sched #(.FRAME_DIV(100), .REFRESH_CYC(150)) dut2 (
        .clk(clk), .rst(rst2), .enable_i(enable_i),
        .render_we_i(render_we_i), .render_addr_i(render_addr_i),
        .render_data_i(render_data_i), .render_done_i(render_done_i),
        .render_ready_o(render_ready_2), .drv_start_o(drv_start_2),
        .drv_addr_i(drv_addr_i), .drv_data_o(drv_data_2),
        .front_sel_o(front_sel_2), .frame_skip_o(frame_skip_2)
    );

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cyc2(input int k);
        while (cyc2 < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        render_we_i = 1'b0;
        render_done_i = 1'b0;
        drv_addr_i = '0;
        enable_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_rdy;
`ifdef LCD_FB_CLEAR_ON_SWAP_EN
        exp_rdy = 1'b0;
`else
        exp_rdy = 1'b1;
`endif
        do_reset();
        checks++;
        if (drv_start_o !== 1'b0) begin
            errors++; $display("FAIL reset_start: got %b want 0", drv_start_o);
        end
        checks++;
        if (front_sel_o !== 1'b0) begin
            errors++; $display("FAIL reset_front: got %b want 0", front_sel_o);
        end
        checks++;
        if (frame_skip_o !== 8'd0) begin
            errors++; $display("FAIL reset_skip: got %0d want 0", frame_skip_o);
        end
        checks++;
        if (drv_data_o !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", drv_data_o);
        end
        checks++;
        if (render_ready_o !== exp_rdy) begin
            errors++; $display("FAIL reset_ready: got %b want %b", render_ready_o, exp_rdy);
        end
    endtask

    task automatic test_start_timing();
        int ks [8] = '{99, 100, 101, 102, 199, 200, 201, 202};
        logic exp;
        foreach (ks[i]) begin
            wait_cyc(ks[i]);
            exp = (ks[i] == 100) || (ks[i] == 101) || (ks[i] == 200) || (ks[i] == 201);
            checks++;
            if (drv_start_o !== exp) begin
                errors++;
                $display("FAIL start_c%0d: got %b want %b", ks[i], drv_start_o, exp);
            end
        end
        checks++;
        if (frame_skip_o !== 8'd0) begin
            errors++; $display("FAIL start_skip: got %0d want 0", frame_skip_o);
        end
        wait_cyc(300);
        checks++;
        if (drv_start_o !== 1'b1) begin
            errors++; $display("FAIL start_c300: got %b want 1", drv_start_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (drv_start_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_start: got %b want 0", drv_start_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_swap();
        do_reset();
        wait_cyc(5);
        render_we_i = 1'b1; render_addr_i = 10'h3FF; render_data_i = 8'hA5;
        wait_cyc(6);
        render_we_i = 1'b0; render_done_i = 1'b1;
        wait_cyc(7);
        render_done_i = 1'b0;
        checks++;
        if (render_ready_o !== 1'b0) begin
            errors++; $display("FAIL swap_ready_low: got %b want 0", render_ready_o);
        end
        wait_cyc(99);
        checks++;
        if (front_sel_o !== 1'b0) begin
            errors++; $display("FAIL swap_front_pre: got %b want 0", front_sel_o);
        end
        wait_cyc(100);
        checks++;
        if (front_sel_o !== 1'b1) begin
            errors++; $display("FAIL swap_front_post: got %b want 1", front_sel_o);
        end
        checks++;
        if (render_ready_o !== 1'b1) begin
            errors++; $display("FAIL swap_ready_back: got %b want 1", render_ready_o);
        end
        drv_addr_i = 10'h3FF;
        wait_cyc(101);
        checks++;
        if (drv_data_o !== 8'hA5) begin
            errors++; $display("FAIL swap_read: got %h want a5", drv_data_o);
        end
    endtask

    task automatic test_double_done();
        wait_cyc(110);
        render_we_i = 1'b1; render_addr_i = 10'h010; render_data_i = 8'h11;
        render_done_i = 1'b1;
        wait_cyc(111);
        render_we_i = 1'b0; render_done_i = 1'b0;
        checks++;
        if (render_ready_o !== 1'b0) begin
            errors++; $display("FAIL dd_ready_low: got %b want 0", render_ready_o);
        end
        wait_cyc(112);
        render_we_i = 1'b1; render_data_i = 8'h22;
        wait_cyc(113);
        render_we_i = 1'b0; render_done_i = 1'b1;
        wait_cyc(114);
        render_done_i = 1'b0;
        wait_cyc(199);
        checks++;
        if (front_sel_o !== 1'b1) begin
            errors++; $display("FAIL dd_front_pre: got %b want 1", front_sel_o);
        end
        wait_cyc(200);
        checks++;
        if (front_sel_o !== 1'b0) begin
            errors++; $display("FAIL dd_front_post: got %b want 0", front_sel_o);
        end
        drv_addr_i = 10'h010;
        wait_cyc(201);
        checks++;
        if (drv_data_o !== 8'h11) begin
            errors++; $display("FAIL dd_read_old: got %h want 11", drv_data_o);
        end
        wait_cyc(300);
        checks++;
        if (front_sel_o !== 1'b0) begin
            errors++; $display("FAIL dd_single_swap: got %b want 0", front_sel_o);
        end
        checks++;
        if (drv_start_o !== 1'b1) begin
            errors++; $display("FAIL dd_start_c300: got %b want 1", drv_start_o);
        end
    endtask

    task automatic test_disable_swap();
        enable_i = 1'b0;
        wait_cyc(301);
        checks++;
        if (drv_start_o !== 1'b1) begin
            errors++; $display("FAIL dis_start_hold: got %b want 1", drv_start_o);
        end
        wait_cyc(302);
        checks++;
        if (drv_start_o !== 1'b0) begin
            errors++; $display("FAIL dis_start_end: got %b want 0", drv_start_o);
        end
        wait_cyc(310);
        render_we_i = 1'b1; render_addr_i = 10'h001; render_data_i = 8'h77;
        render_done_i = 1'b1;
        wait_cyc(311);
        render_we_i = 1'b0; render_done_i = 1'b0;
        wait_cyc(400);
        checks++;
        if (drv_start_o !== 1'b0) begin
            errors++; $display("FAIL dis_no_start: got %b want 0", drv_start_o);
        end
        checks++;
        if (front_sel_o !== 1'b1) begin
            errors++; $display("FAIL dis_front: got %b want 1", front_sel_o);
        end
        checks++;
        if (render_ready_o !== 1'b1) begin
            errors++; $display("FAIL dis_ready: got %b want 1", render_ready_o);
        end
        drv_addr_i = 10'h001;
        wait_cyc(401);
        checks++;
        if (drv_start_o !== 1'b0) begin
            errors++; $display("FAIL dis_no_start2: got %b want 0", drv_start_o);
        end
        checks++;
        if (drv_data_o !== 8'h77) begin
            errors++; $display("FAIL dis_read: got %h want 77", drv_data_o);
        end
        enable_i = 1'b1;
    endtask

`ifdef LCD_FB_CLEAR_ON_SWAP_EN
    task automatic test_clear();
        do_reset();
        wait_cyc(1023);
        checks++;
        if (render_ready_o !== 1'b0) begin
            errors++; $display("FAIL clr_rst_busy: got %b want 0", render_ready_o);
        end
        wait_cyc(1024);
        checks++;
        if (render_ready_o !== 1'b1) begin
            errors++; $display("FAIL clr_rst_done: got %b want 1", render_ready_o);
        end
        wait_cyc(1030);
        render_we_i = 1'b1; render_addr_i = 10'h005; render_data_i = 8'hCC;
        render_done_i = 1'b1;
        wait_cyc(1031);
        render_we_i = 1'b0; render_done_i = 1'b0;
        wait_cyc(1100);
        checks++;
        if (front_sel_o !== 1'b1) begin
            errors++; $display("FAIL clr_front1: got %b want 1", front_sel_o);
        end
        drv_addr_i = 10'h005;
        wait_cyc(1101);
        checks++;
        if (drv_data_o !== 8'hCC) begin
            errors++; $display("FAIL clr_read_cc: got %h want cc", drv_data_o);
        end
        wait_cyc(2123);
        checks++;
        if (render_ready_o !== 1'b0) begin
            errors++; $display("FAIL clr_swap_busy: got %b want 0", render_ready_o);
        end
        wait_cyc(2124);
        checks++;
        if (render_ready_o !== 1'b1) begin
            errors++; $display("FAIL clr_swap_done: got %b want 1", render_ready_o);
        end
        wait_cyc(2130);
        render_we_i = 1'b1; render_addr_i = 10'h3FF; render_data_i = 8'hEE;
        render_done_i = 1'b1;
        wait_cyc(2131);
        render_we_i = 1'b0; render_done_i = 1'b0;
        wait_cyc(2200);
        drv_addr_i = 10'h3FF;
        wait_cyc(2201);
        checks++;
        if (drv_data_o !== 8'hEE) begin
            errors++; $display("FAIL clr_read_ee: got %h want ee", drv_data_o);
        end
        wait_cyc(3230);
        render_done_i = 1'b1;
        wait_cyc(3231);
        render_done_i = 1'b0;
        wait_cyc(3300);
        checks++;
        if (front_sel_o !== 1'b1) begin
            errors++; $display("FAIL clr_front3: got %b want 1", front_sel_o);
        end
        drv_addr_i = 10'h005;
        wait_cyc(3301);
        checks++;
        if (drv_data_o !== 8'h00) begin
            errors++; $display("FAIL clr_zero_005: got %h want 00", drv_data_o);
        end
        drv_addr_i = 10'h3FF;
        wait_cyc(3302);
        checks++;
        if (drv_data_o !== 8'h00) begin
            errors++; $display("FAIL clr_zero_3ff: got %h want 00", drv_data_o);
        end
    endtask
`endif

    task automatic test_skip();
        int ks [5] = '{200, 300, 50800, 51000, 51200};
        int ev [5] = '{1, 1, 254, 255, 255};
        enable_i = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        wait_cyc2(200);
        checks++;
        if (drv_start_2 !== 1'b0) begin
            errors++; $display("FAIL skip_no_start: got %b want 0", drv_start_2);
        end
        wait_cyc2(300);
        checks++;
        if (drv_start_2 !== 1'b1) begin
            errors++; $display("FAIL skip_start_c300: got %b want 1", drv_start_2);
        end
        foreach (ks[i]) begin
            wait_cyc2(ks[i]);
            checks++;
            if (frame_skip_2 !== 8'(ev[i])) begin
                errors++;
                $display("FAIL skip_c%0d: got %0d want %0d", ks[i], frame_skip_2, ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_timing();
`ifdef LCD_FB_CLEAR_ON_SWAP_EN
        test_clear();
`else
        test_swap();
        test_double_done();
        test_disable_swap();
`endif
        test_skip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_frame_sched.md
Name: lcd_frame_sched

Overview:
- Frame scheduler and double-buffer owner for the LCD refresh path.
- Holds two 1024x8 framebuffer banks. The renderer writes the back bank; the LCD Driver reads the front bank through its addr/data port.
- Issues periodic start pulses to the Driver.
- Swaps banks only at frame boundaries, so the panel never shows a half-rendered frame.

Parameters:
- FRAME_DIV, 1666667: clk cycles per frame tick (30 Hz at 50 MHz); legal range 4..2^24-1.
- REFRESH_CYC, 1200000: cycles the front bank stays locked after a start (covers one full Driver refresh); must be < FRAME_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable_i  in  1  allow new refresh starts
- render_we_i  in  1  back-bank write strobe
- render_addr_i  in  10  back-bank write address {x[3:0], y[5:0]}
- render_data_i  in  8  back-bank write data
- render_done_i  in  1  1-cycle pulse: back frame complete, request swap
- render_ready_o  out  1  writes accepted (no swap pending, no clear running)
- drv_start_o  out  1  to Driver start_i
- drv_addr_i  in  10  from Driver addr_o
- drv_data_o  out  8  to Driver data_i
- front_sel_o  out  1  bank currently displayed
- frame_skip_o  out  8  saturating count of frame ticks lost to overrun

Behaviour:
- Reset values: drv_start_o=0, front_sel_o=0, frame_skip_o=0, drv_data_o=0, render_ready_o=1 (0 when the feature below is compiled in). Frame counter=0, swap_pending=0, state=IDLE.
- Frame counter counts 0..FRAME_DIV-1 and wraps. tick=1 on the cycle the count equals FRAME_DIV-1.
- FSM states and transitions:
  - IDLE: on tick with enable_i=1 -> apply swap if pending (toggle front_sel_o, clear swap_pending), then go to START. On tick with enable_i=0 -> stay IDLE; a pending swap is still applied.
  - START: drv_start_o=1 for exactly 2 cycles, then deasserted. The Driver acts on the falling edge. The front bank is locked from the first START cycle.
  - REFRESH: lasts REFRESH_CYC cycles from START exit, then -> IDLE.
- Tick arriving in START or REFRESH: no start is issued, frame_skip_o increments (saturates at 255), and no swap occurs.
- enable_i dropping mid-refresh: the current START/REFRESH completes normally.
- Read path: drv_data_o is registered = bank[front_sel_o][drv_addr_i], 1-cycle latency, always active in every state.
- Write path: when render_we_i=1 and render_ready_o=1, write bank[~front_sel_o][render_addr_i]. Writes while render_ready_o=0 are dropped silently.
- render_done_i handling:
  - With render_ready_o=1: sets swap_pending and drops render_ready_o.
  - With swap_pending already set: ignored.
  - Simultaneous with render_we_i on the same cycle: the write lands, then the swap is requested.
- render_ready_o reasserts the cycle after the swap is applied.
- After a swap, the back bank holds the previously displayed frame; the renderer redraws it fully.
- rst mid-refresh: FSM returns to IDLE and drv_start_o=0 immediately on the next edge. Bank contents are not cleared (without the feature).

Optional Feature:
- Macro: LCD_FB_CLEAR_ON_SWAP_EN.
- Defined: after every swap, and after reset, a clear engine writes 0x00 to all 1024 back-bank addresses, one per cycle, ascending. render_ready_o stays 0 for those 1024 cycles and reasserts on cycle 1025. Reset during a clear restarts the clear from address 0.
- Undefined: no clear engine; the back bank keeps stale data; render_ready_o is 1 out of reset and reasserts the cycle after a swap.

Decomposition:
- Shared package lcd_pkg:
  - FB_ADDR_W=10, FB_DATA_W=8, FB_DEPTH=1024
  - START_PULSE_CYC=2
  - sched_state_t enum {IDLE, START, REFRESH}
- Sub-module fb_bank: simple dual-port 1024x8 RAM, one synchronous write port, one registered read port. Instantiated twice; bank select muxing lives in the top.

Test Plan (FRAME_DIV=100, REFRESH_CYC=40 unless noted):
- Reset, enable_i=1 -> first drv_start_o high at cycles 100-101 after reset release, low thereafter; next start at cycle 200; frame_skip_o=0.
- Write 0xA5 @addr 0x3FF, pulse render_done_i -> render_ready_o=0; at the next tick front_sel_o=1; drv_addr_i=0x3FF gives drv_data_o=0xA5 one cycle later.
- render_done_i pulsed twice before the tick, with a write in between -> one swap only; the second write is dropped (old value still read after the swap).
- REFRESH_CYC=150, FRAME_DIV=100 -> every other tick is skipped; frame_skip_o reaches 255 and holds.
- enable_i=0 with swap pending -> no drv_start_o, but front_sel_o toggles at the tick.
- With LCD_FB_CLEAR_ON_SWAP_EN: after a swap, render_ready_o is low for exactly 1024 cycles; all back-bank reads after the next swap return 0x00.
